// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared constants and sizing helpers for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;
    localparam int BURST_CNT_W    = 10;
    localparam int DATA_WIDTH_MIN = 1;
    localparam int DATA_WIDTH_MAX = 256;
    localparam int RD_LATENCY_MIN = 0;
    localparam int RD_LATENCY_MAX = 2;
    localparam int BURST_LEN_MIN  = 1;
    localparam int BURST_LEN_MAX  = 1 << BURST_CNT_W;

    // One slot per read in flight, plus two so issue can continue while the head waits.
    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

    function automatic int level_width(input int rd_latency);
        return $clog2(buf_depth(rd_latency) + 1);
    endfunction
endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read port and downstream stream signals seen by the adapter.
interface fifo_rd_stream_adapter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Small register ring: tail written on push, head presented straight from the registers.
module fifo_rd_skid_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3,
    parameter int LEVEL_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [LEVEL_W-1:0]    level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a fixed-latency FIFO read port into a valid/ready stream with burst framing.
module fifo_rd_stream_adapter
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int BURST_LEN  = 16,
    localparam int BUF_DEPTH = buf_depth(RD_LATENCY),
    localparam int LEVEL_W   = level_width(RD_LATENCY)
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    fifo_rd_stream_adapter_if.master bus,
    output logic [LEVEL_W-1:0]       buf_level
);
    localparam logic [LEVEL_W-1:0]     CREDIT_MAX = LEVEL_W'(BUF_DEPTH);
    localparam logic [BURST_CNT_W-1:0] BEAT_LAST  = BURST_CNT_W'(BURST_LEN - 1);

    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_data_width
        $error("fifo_rd_stream_adapter: DATA_WIDTH out of range");
    end
    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_rd_latency
        $error("fifo_rd_stream_adapter: RD_LATENCY out of range");
    end
    if (BURST_LEN < BURST_LEN_MIN || BURST_LEN > BURST_LEN_MAX) begin : g_bad_burst_len
        $error("fifo_rd_stream_adapter: BURST_LEN out of range");
    end

    logic [LEVEL_W-1:0]     credit;
    logic [BURST_CNT_W-1:0] beat_cnt;
    logic                   issue;
    logic                   capture;
    logic                   handshake;

    // Credit is registered, so m_ready never reaches fifo_rd_en combinationally.
    assign issue          = !bus.fifo_empty && (credit < CREDIT_MAX) && !rd_rst;
    assign bus.fifo_rd_en = issue;
    assign handshake      = bus.m_valid && bus.m_ready;

    if (RD_LATENCY == 0) begin : g_show_ahead
        assign capture = issue;
    end else if (RD_LATENCY == 1) begin : g_lat1
        logic inflight;
        always_ff @(posedge rd_clk or posedge rd_rst) begin
            if (rd_rst) inflight <= 1'b0;
            else        inflight <= issue;
        end
        assign capture = inflight;
    end else begin : g_latn
        logic [RD_LATENCY-1:0] inflight;
        always_ff @(posedge rd_clk or posedge rd_rst) begin
            if (rd_rst) inflight <= '0;
            else        inflight <= {inflight[RD_LATENCY-2:0], issue};
        end
        assign capture = inflight[RD_LATENCY-1];
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            credit <= '0;
        end else begin
            case ({issue, handshake})
                2'b10:   credit <= credit + LEVEL_W'(1);
                2'b01:   credit <= credit - LEVEL_W'(1);
                default: credit <= credit;
            endcase
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            beat_cnt <= '0;
        end else if (handshake) begin
            beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + BURST_CNT_W'(1);
        end
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH),
        .LEVEL_W    (LEVEL_W)
    ) u_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (capture),
        .push_data (bus.fifo_rd_data),
        .pop       (handshake),
        .head      (bus.m_data),
        .level     (buf_level)
    );

    assign bus.m_valid = (buf_level != '0);
    assign bus.m_last  = bus.m_valid && (beat_cnt == BEAT_LAST);
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Scoreboard bench: lane 0 RD_LATENCY=1/BURST_LEN=16, lane 1 RD_LATENCY=2, lane 2 BURST_LEN=1.
module tb_fifo_rd_stream_adapter;
    localparam int DW = 32;
    localparam int NL = 3;

    logic rd_clk = 1'b0;
    logic rd_rst = 1'b1;
    always #5 rd_clk = ~rd_clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fq   [NL][$];
    logic [DW:0]   expq [NL][$];
    int beat_idx  [NL] = '{default: 0};
    int rd_en_cnt [NL] = '{default: 0};
    int hs_cnt    [NL] = '{default: 0};
    int max_cred  [NL] = '{default: 0};

    logic [NL-1:0] ready_drv = '0;
    logic [NL-1:0] obs_rd_en;
    logic [NL-1:0] obs_valid;
    logic [NL-1:0] obs_last;
    logic [DW-1:0] obs_data  [NL];
    logic [2:0]    obs_level [NL];

    int first_rd, last_rd, n_rd, first_val, last_val, n_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int bl_of(input int l);
        return (l == 2) ? 1 : 16;
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int LAT  = (g == 1) ? 2 : 1;
        localparam int BLEN = (g == 2) ? 1 : 16;
        localparam int LW   = (g == 1) ? 3 : 2;

        fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();
        logic [LW-1:0] buf_level;
        logic [DW-1:0] pipe0 = '0;
        logic [DW-1:0] pipe1 = '0;
        logic          empty_q = 1'b1;
        logic          rd_en_s = 1'b0;
        logic          hold_pend = 1'b0;
        logic [DW:0]   hold_val = '0;
        logic [DW:0]   exp_v;

        fifo_rd_stream_adapter #(
            .DATA_WIDTH (DW),
            .RD_LATENCY (LAT),
            .BURST_LEN  (BLEN)
        ) dut (
            .rd_clk    (rd_clk),
            .rd_rst    (rd_rst),
            .bus       (bus),
            .buf_level (buf_level)
        );

        assign bus.fifo_empty   = empty_q;
        assign bus.fifo_rd_data = (LAT == 2) ? pipe1 : pipe0;
        assign bus.m_ready      = ready_drv[g];
        assign obs_rd_en[g]     = bus.fifo_rd_en;
        assign obs_valid[g]     = bus.m_valid;
        assign obs_last[g]      = bus.m_last;
        assign obs_data[g]      = bus.m_data;
        assign obs_level[g]     = 3'(buf_level);

        // FIFO read-port model: pops on a sampled rd_en, data emerges LAT cycles later.
        always @(posedge rd_clk or posedge rd_rst) begin
            if (rd_rst) begin
                pipe0   <= '0;
                pipe1   <= '0;
                empty_q <= 1'b1;
            end else begin
                logic [DW-1:0] w;
                w = '0;
                if (rd_en_s) begin
                    check($sformatf("fifo_underflow_l%0d", g), 64'(fq[g].size() == 0), 64'(0));
                    if (fq[g].size() != 0) w = fq[g].pop_front();
                end
                pipe0   <= w;
                pipe1   <= pipe0;
                empty_q <= (fq[g].size() == 0);
            end
        end

        // Monitor: compares every accepted beat against the scoreboard and checks hold.
        always @(negedge rd_clk) begin
            rd_en_s = bus.fifo_rd_en;
            if (rd_rst) begin
                hold_pend = 1'b0;
            end else begin
                if (rd_en_cnt[g] - hs_cnt[g] > max_cred[g]) max_cred[g] = rd_en_cnt[g] - hs_cnt[g];
                if (hold_pend)
                    check($sformatf("hold_l%0d", g), 64'({bus.m_valid, bus.m_last, bus.m_data}),
                          64'({1'b1, hold_val}));
                if (bus.m_valid && ready_drv[g]) begin
                    hs_cnt[g]++;
                    if (expq[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_unexpected_l%0d: got 0x%0h, expected no beat", g, bus.m_data);
                    end else begin
                        exp_v = expq[g].pop_front();
                        check($sformatf("beat_l%0d", g), 64'({bus.m_last, bus.m_data}), 64'(exp_v));
                    end
                end
                if (bus.fifo_rd_en) rd_en_cnt[g]++;
                hold_pend = bus.m_valid && !ready_drv[g];
                hold_val  = {bus.m_last, bus.m_data};
            end
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_words(input int l, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            fq[l].push_back(DW'(base + i));
            expq[l].push_back({(beat_idx[l] % bl_of(l)) == bl_of(l) - 1, DW'(base + i)});
            beat_idx[l]++;
        end
    endtask

    task automatic observe(input int l, input int n);
        first_rd = -1; last_rd = -1; n_rd = 0;
        first_val = -1; last_val = -1; n_val = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge rd_clk);
            if (obs_rd_en[l]) begin
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                n_rd++;
            end
            if (obs_valid[l]) begin
                if (first_val < 0) first_val = c;
                last_val = c;
                n_val++;
            end
        end
        tick();
    endtask

    task automatic drain(input int l, input int budget, input string name);
        int c;
        c = 0;
        while (expq[l].size() != 0 && c < budget) begin
            @(negedge rd_clk);
            #1;
            c++;
        end
        check(name, 64'(expq[l].size()), 64'(0));
        tick();
    endtask

    // Reset is shared with the FIFO model: queued and in-flight words are discarded.
    task automatic pulse_reset(input int cycles);
        rd_rst = 1'b1;
        for (int l = 0; l < NL; l++) begin
            fq[l].delete();
            expq[l].delete();
            beat_idx[l]  = 0;
            rd_en_cnt[l] = 0;
            hs_cnt[l]    = 0;
        end
        repeat (cycles) begin
            @(negedge rd_clk);
            check("rst_rd_en", 64'(obs_rd_en[0]), 64'(0));
            check("rst_m_valid", 64'(obs_valid[0]), 64'(0));
            check("rst_m_last", 64'(obs_last[0]), 64'(0));
            check("rst_m_data", 64'(obs_data[0]), 64'(0));
            check("rst_buf_level", 64'(obs_level[0]), 64'(0));
            tick();
        end
        rd_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c;
        tick();
        pulse_reset(2);

        // Lane 0: 20 words streaming back to back
        ready_drv[0] = 1'b1;
        push_words(0, 0, 20);
        observe(0, 30);
        check("t1_first_rd", 64'(first_rd), 64'(1));
        check("t1_rd_count", 64'(n_rd), 64'(20));
        check("t1_rd_span", 64'(last_rd - first_rd), 64'(19));
        check("t1_latency", 64'(first_val - first_rd), 64'(2));
        check("t1_val_count", 64'(n_val), 64'(20));
        check("t1_val_span", 64'(last_val - first_val), 64'(19));
        check("t1_drained", 64'(expq[0].size()), 64'(0));

        // Lane 0: stalled consumer fills exactly BUF_DEPTH=3 credits
        ready_drv[0] = 1'b0;
        push_words(0, 32'h100, 8);
        observe(0, 12);
        check("t2_rd_count", 64'(n_rd), 64'(3));
        @(negedge rd_clk);
        check("t2_level", 64'(obs_level[0]), 64'(3));
        check("t2_valid", 64'(obs_valid[0]), 64'(1));
        check("t2_head", 64'(obs_data[0]), 64'(32'h100));
        tick();
        ready_drv[0] = 1'b1;
        drain(0, 30, "t2_drained");

        // Lane 0: empty FIFO, then a single word
        observe(0, 10);
        check("t3_idle_rd", 64'(n_rd), 64'(0));
        check("t3_idle_valid", 64'(n_val), 64'(0));
        push_words(0, 32'hABC, 1);
        observe(0, 10);
        check("t3_rd_count", 64'(n_rd), 64'(1));
        check("t3_val_count", 64'(n_val), 64'(1));
        check("t3_drained", 64'(expq[0].size()), 64'(0));

        // Lane 0: reset while burst beat 7 is presented (29 beats so far + 10 = 39)
        push_words(0, 32'h200, 20);
        base = hs_cnt[0];
        c = 0;
        while (hs_cnt[0] - base < 10 && c < 40) begin
            @(negedge rd_clk);
            #1;
            c++;
        end
        check("t5_reached_beat", 64'(hs_cnt[0] - base), 64'(10));
        tick();
        pulse_reset(1);
        push_words(0, 32'h300, 20);
        drain(0, 40, "t5_drained");

        // Lane 1 (RD_LATENCY=2): ready toggling 1010
        push_words(1, 32'h400, 32);
        for (int k = 0; k < 120 && expq[1].size() != 0; k++) begin
            ready_drv[1] = (k % 2 == 0);
            tick();
        end
        check("l1_toggle_drained", 64'(expq[1].size()), 64'(0));
        check("l1_credit_le4", 64'(max_cred[1] <= 4), 64'(1));

        // Lane 1: full-rate run shows RD_LATENCY+1 first-word latency
        ready_drv[1] = 1'b1;
        tick();
        push_words(1, 32'h480, 8);
        observe(1, 20);
        check("l1_rd_count", 64'(n_rd), 64'(8));
        check("l1_latency", 64'(first_val - first_rd), 64'(3));
        check("l1_val_count", 64'(n_val), 64'(8));
        check("l1_val_span", 64'(last_val - first_val), 64'(7));
        check("l1_credit_max4", 64'(max_cred[1] <= 4), 64'(1));

        // Lane 2 (BURST_LEN=1): every beat is last
        ready_drv[2] = 1'b1;
        push_words(2, 32'h500, 4);
        observe(2, 12);
        check("l2_val_count", 64'(n_val), 64'(4));
        check("l2_drained", 64'(expq[2].size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
